prbs9_ber_checker: RTL and testbench
====================================

Name: prbs9_ber_checker

Overview:
- Receive-side stage directly downstream of the polyphase FIR shaping filter.
- Decimates the OS-rate filter output to one sample per symbol at a selectable phase, slices the sign to a bit, self-synchronises a local PRBS9 (b[n] = b[n-9] ^ b[n-5]) and counts checked bits and bit errors.
- Drives lock/status to top for LEDs and sweeps.

Parameters:
- NB_DATA, 8, width of signed filter output sample
- OS, 4, oversampling factor, power of 2
- NB_PHASE, $clog2(OS), width of phase select
- NB_CNT, 32, width of bit/error counters
- RESYNC_WIN, 64, symbols per error-monitor window
- RESYNC_THR, 8, errors within one window that force resync

Ports:
- clock  in  1  system clock
- i_reset  in  1  reset, asynchronous, active-low
- i_enable  in  1  checker enable (tx-enable switch)
- i_valid  in  1  one-cycle strobe per filter output sample
- i_data  in  NB_DATA  signed filter output sample
- i_phase  in  NB_PHASE  decimation phase, 0..OS-1
- i_clear  in  1  synchronous clear of counters
- o_rx_bit  out  1  last sliced symbol bit
- o_locked  out  1  high in CHECK state
- o_bit_count  out  NB_CNT  symbols compared in CHECK
- o_err_count  out  NB_CNT  mismatches in CHECK

Behaviour:
- Reset (async, i_reset=0): state IDLE, all outputs 0, decim counter 0, LFSR 0, window counters 0.
- Decim counter: increments mod OS on each i_valid. A symbol event is i_valid && counter==i_phase.
- Slicer: rx = i_data[NB_DATA-1] (negative -> 1). Sample 0 slices to 0.
- All state, LFSR and counter updates occur on the symbol-event edge. Outputs are visible the next cycle (latency 1).
- IDLE:
  - Leave to LOAD when i_enable=1.
  - i_enable=0 in any state -> IDLE next edge. Counters hold. o_locked=0.
- LOAD:
  - Shift rx into lfsr[0]; lfsr <= {lfsr[7:0], rx}.
  - Load counter counts to 9, then CHECK. Load counter and window counters are cleared on entry.
- CHECK:
  - exp = lfsr[8]^lfsr[4]. lfsr <= {lfsr[7:0], exp}; the LFSR free-runs and never loads rx.
  - bit_count += 1; err_count += (rx != exp); both saturate at all-ones.
  - Window: win_cnt counts symbols and win_err counts errors.
    - If win_err reaches RESYNC_THR -> LOAD at once; cumulative counters are kept.
    - When win_cnt reaches RESYNC_WIN, both window counters reset to 0.
- i_phase change (registered compare) while in LOAD or CHECK -> LOAD on the next edge.
- i_clear: zeroes bit/err counters. It has priority over a same-cycle increment. It does not affect state or LFSR.
- A single isolated channel bit flip yields exactly 1 error, because the reference does not propagate errors.
- The all-zero LFSR after LOAD (rx all 0, i.e. filter silent) is legal. The window threshold then forces resync if real data disagrees.

Optional Feature:
- Macro BER_CHECKER_STICKY_LOL_EN.
- When defined: extra port o_lol_sticky (out, 1).
  - Set on every CHECK -> LOAD transition caused by threshold or phase change.
  - Cleared by i_clear or reset.
  - Set wins over a same-cycle clear.
- When not defined: port and logic are absent.

Decomposition:
- Shared package (ber_pkg): state encoding (IDLE/LOAD/CHECK localparams), PRBS9 tap positions (8, 4), LFSR length 9.
- One sub-module, prbs9_ref_lfsr, is natural: 9-bit register with load-shift/free-run select and exp output.
- Decimator, slicer, FSM and counters stay in the top of the block.

Test Plan:
- Ideal stream: PRBS9 seed 0x1AA mapped 0 -> +64, 1 -> -64, each held OS strobes, i_phase=0, i_enable=1.
  - Expected: o_locked rises after 9 symbols.
  - After 1000 symbols: o_bit_count=991, o_err_count=0.
- Flip symbols 200, 450, 700 in the locked stream -> o_err_count=3, o_locked stays 1.
- Burst of 8 flipped symbols inside one window -> o_locked drops.
  - Relock 9 symbols later.
  - o_bit_count keeps counting; o_err_count=8.
  - With BER_CHECKER_STICKY_LOL_EN, o_lol_sticky=1 until i_clear.
- Change i_phase 0 -> 2 while locked -> LOAD next edge, o_locked=0.
  - Relock after 9 symbols with 0 errors: the ideal stream is constant across OS.
- NB_CNT=8 override, 300 locked symbols -> o_bit_count saturates at 255.
  - Pulse i_clear -> both counts 0 next cycle while o_locked stays 1.
- Assert i_reset=0 mid-CHECK asynchronously -> outputs 0 immediately.
  - Release -> relock in 9 symbols.
  - i_enable=0 -> IDLE, counters hold.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS9 BER checker: FSM state encoding and PRBS9
// tap geometry (b[n] = b[n-9] ^ b[n-5]).
package ber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int LFSR_LEN = 9;
  localparam int TAP_A    = 8;
  localparam int TAP_B    = 4;
  localparam int NB_LOAD  = $clog2(LFSR_LEN + 1);

  function automatic logic prbs9_next(input logic [LFSR_LEN-1:0] lfsr);
    return lfsr[TAP_A] ^ lfsr[TAP_B];
  endfunction

endpackage

// File: rtl/prbs9_ref_lfsr.sv
// Local PRBS9 reference: shifts received bits in while loading, otherwise
// free-runs on its own feedback so channel errors never propagate.
module prbs9_ref_lfsr
  import ber_pkg::*;
(
  input  logic clock,
  input  logic i_reset,
  input  logic i_shift,
  input  logic i_load,
  input  logic i_rx,
  output logic o_exp
);

  logic [LFSR_LEN-1:0] lfsr_q;
  logic [LFSR_LEN-1:0] lfsr_d;
  logic                exp_bit;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    exp_bit = prbs9_next(lfsr_q);
    lfsr_d  = lfsr_q;
    if (i_shift) begin
      lfsr_d = {lfsr_q[LFSR_LEN-2:0], (i_load ? i_rx : exp_bit)};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end

  assign o_exp = exp_bit;

endmodule

// File: rtl/prbs9_ber_checker.sv
// PRBS9 bit-error-rate checker: decimate, slice, self-synchronise, count.
// Optional sticky loss-of-lock flag under macro BER_CHECKER_STICKY_LOL_EN.
module prbs9_ber_checker
  import ber_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OS         = 4,
  parameter int NB_PHASE   = $clog2(OS),
  parameter int NB_CNT     = 32,
  parameter int RESYNC_WIN = 64,
  parameter int RESYNC_THR = 8
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_data,
  input  logic        [NB_PHASE-1:0] i_phase,
  input  logic                       i_clear,
  output logic                       o_rx_bit,
  output logic                       o_locked,
  output logic        [NB_CNT-1:0]   o_bit_count,
  output logic        [NB_CNT-1:0]   o_err_count
`ifdef BER_CHECKER_STICKY_LOL_EN
  ,
  output logic                       o_lol_sticky
`endif
);

  localparam int NB_WIN  = $clog2(RESYNC_WIN);
  localparam int NB_WERR = $clog2(RESYNC_THR + 1);

  state_t              state_q, state_d;
  logic [NB_PHASE-1:0] dec_q, dec_d;
  logic [NB_PHASE-1:0] phase_q;
  logic                rx_q, rx_d;
  logic [NB_LOAD-1:0]  load_q, load_d;
  logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
  logic [NB_WERR-1:0]  win_err_q, win_err_d, win_err_inc;
  logic [NB_CNT-1:0]   bit_q, bit_d;
  logic [NB_CNT-1:0]   err_q, err_d;

  logic sym, rx, exp_bit, mismatch, phase_chg, enter_load;
  logic lfsr_shift, lfsr_load;

  // Only the sign bit is sliced; the magnitude is intentionally ignored.
  logic data_unused;
  assign data_unused = ^i_data[NB_DATA-2:0];

  assign dec_d       = i_valid ? dec_q + 1'b1 : dec_q;
  assign sym         = i_valid && (dec_q == i_phase);
  assign rx          = i_data[NB_DATA-1];
  assign phase_chg   = (i_phase != phase_q);
  assign mismatch    = rx ^ exp_bit;
  assign win_err_inc = win_err_q + NB_WERR'(mismatch);

  prbs9_ref_lfsr u_ref (
    .clock   (clock),
    .i_reset (i_reset),
    .i_shift (lfsr_shift),
    .i_load  (lfsr_load),
    .i_rx    (rx),
    .o_exp   (exp_bit)
  );

  always_comb begin
    state_d    = state_q;
    rx_d       = sym ? rx : rx_q;
    load_d     = load_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    bit_d      = bit_q;
    err_d      = err_q;
    lfsr_shift = 1'b0;
    lfsr_load  = 1'b0;
    enter_load = 1'b0;

    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: enter_load = 1'b1;
        ST_LOAD: begin
          if (phase_chg) begin
            enter_load = 1'b1;
          end else if (sym) begin
            lfsr_shift = 1'b1;
            lfsr_load  = 1'b1;
            load_d     = load_q + 1'b1;
            if (load_q == NB_LOAD'(LFSR_LEN - 1)) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (phase_chg) begin
            enter_load = 1'b1;
          end else if (sym) begin
            lfsr_shift = 1'b1;
            if (!(&bit_q))             bit_d = bit_q + 1'b1;
            if (mismatch && !(&err_q)) err_d = err_q + 1'b1;
            // Too many errors in this window means the reference has slipped.
            if (win_err_inc == NB_WERR'(RESYNC_THR)) begin
              enter_load = 1'b1;
            end else if (win_cnt_q == NB_WIN'(RESYNC_WIN - 1)) begin
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
              win_err_d = win_err_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (enter_load) begin
      state_d   = ST_LOAD;
      load_d    = '0;
      win_cnt_d = '0;
      win_err_d = '0;
    end

    if (i_clear) begin
      bit_d = '0;
      err_d = '0;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      dec_q     <= '0;
      phase_q   <= '0;
      rx_q      <= 1'b0;
      load_q    <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      bit_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      phase_q   <= i_phase;
      rx_q      <= rx_d;
      load_q    <= load_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
    end
  end

  assign o_rx_bit    = rx_q;
  assign o_locked    = (state_q == ST_CHECK);
  assign o_bit_count = bit_q;
  assign o_err_count = err_q;

`ifdef BER_CHECKER_STICKY_LOL_EN
  logic lol_q, lol_d;

  // Only threshold or phase-change resyncs move CHECK to LOAD.
  always_comb begin
    lol_d = lol_q;
    if (i_clear) lol_d = 1'b0;
    if ((state_q == ST_CHECK) && (state_d == ST_LOAD)) lol_d = 1'b1;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) lol_q <= 1'b0;
    else          lol_q <= lol_d;
  end

  assign o_lol_sticky = lol_q;
`endif

endmodule

// File: tb/tb_prbs9_ber_checker.sv
// Directed bench for prbs9_ber_checker: ideal PRBS9 stream, isolated flips,
// error burst resync, phase change, counter saturation, async reset, disable.
module tb_prbs9_ber_checker;

  localparam int OS       = 4;
  localparam int NB_DATA  = 8;
  localparam int NB_PHASE = 2;

  logic                      clock    = 1'b0;
  logic                      i_reset  = 1'b0;
  logic                      i_enable = 1'b0;
  logic                      i_valid  = 1'b0;
  logic                      i_clear  = 1'b0;
  logic signed [NB_DATA-1:0] i_data   = '0;
  logic [NB_PHASE-1:0]       i_phase  = '0;

  logic        rx_bit, locked, rx_bit8, locked8;
  logic [31:0] bit_cnt, err_cnt;
  logic [7:0]  bit_cnt8, err_cnt8;
`ifdef BER_CHECKER_STICKY_LOL_EN
  logic        lol, lol8;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] gen      = 9'h1AA;
  logic       last_bit = 1'b0;

  always #5 clock = ~clock;

  prbs9_ber_checker #(.NB_DATA(NB_DATA), .OS(OS), .NB_CNT(32)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_phase     (i_phase),
    .i_clear     (i_clear),
    .o_rx_bit    (rx_bit),
    .o_locked    (locked),
    .o_bit_count (bit_cnt),
    .o_err_count (err_cnt)
`ifdef BER_CHECKER_STICKY_LOL_EN
    ,
    .o_lol_sticky(lol)
`endif
  );

  prbs9_ber_checker #(.NB_DATA(NB_DATA), .OS(OS), .NB_CNT(8)) dut8 (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_phase     (i_phase),
    .i_clear     (i_clear),
    .o_rx_bit    (rx_bit8),
    .o_locked    (locked8),
    .o_bit_count (bit_cnt8),
    .o_err_count (err_cnt8)
`ifdef BER_CHECKER_STICKY_LOL_EN
    ,
    .o_lol_sticky(lol8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One PRBS9 symbol (optionally inverted on the channel), held for OS strobes.
  task automatic send_symbol(input logic flip);
    logic b;
    b        = gen[8] ^ gen[4];
    gen      = {gen[7:0], b};
    last_bit = b ^ flip;
    for (int k = 0; k < OS; k++) begin
      i_data  = last_bit ? -8'sd64 : 8'sd64;
      i_valid = 1'b1;
      tick(1);
      i_valid = 1'b0;
      tick(1);
    end
  endtask

  task automatic send_ideal(input int n);
    for (int i = 0; i < n; i++) send_symbol(1'b0);
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("reset_locked", locked, 0);
    check("reset_bits", bit_cnt, 0);
    check("reset_errs", err_cnt, 0);
    check("reset_rx", rx_bit, 0);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("reset_lol", lol, 0);
`endif
    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_phase  = 2'd0;
    tick(1);

    // Ideal stream: lock after 9 symbols, 991 of 1000 checked
    send_ideal(8);
    check("load_not_locked", locked, 0);
    send_ideal(1);
    check("lock_after_9", locked, 1);
    check("lock_bits", bit_cnt, 0);
    check("lock_rx_bit", rx_bit, last_bit);
    send_ideal(200);
    check("bits_200", bit_cnt, 200);
    check("bits8_200", bit_cnt8, 200);
    send_ideal(791);
    check("ideal_bits", bit_cnt, 991);
    check("ideal_errs", err_cnt, 0);
    check("ideal_locked", locked, 1);
    check("sat8_bits", bit_cnt8, 255);
    check("sat8_errs", err_cnt8, 0);

    // Clear while locked
    pulse_clear();
    check("clr_bits", bit_cnt, 0);
    check("clr_errs", err_cnt, 0);
    check("clr8_bits", bit_cnt8, 0);
    check("clr8_errs", err_cnt8, 0);
    check("clr_locked", locked, 1);
    check("clr8_locked", locked8, 1);

    // Isolated flips at 200, 450, 700
    for (int s = 0; s < 800; s++) send_symbol((s == 200) || (s == 450) || (s == 700));
    check("flip_errs", err_cnt, 3);
    check("flip_bits", bit_cnt, 800);
    check("flip_locked", locked, 1);
    check("flip8_errs", err_cnt8, 3);
    check("flip8_bits", bit_cnt8, 255);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("flip_lol", lol, 0);
`endif

    // Burst of 8: 1791 symbols checked since lock, so one more closes the
    // current window and the burst fills the start of a fresh one.
    pulse_clear();
    send_ideal(1);
    for (int s = 0; s < 8; s++) send_symbol(1'b1);
    check("burst_unlocked", locked, 0);
    check("burst_errs", err_cnt, 8);
    check("burst_bits", bit_cnt, 9);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("burst_lol", lol, 1);
`endif
    send_ideal(8);
    check("relock_pending", locked, 0);
    send_ideal(1);
    check("relock", locked, 1);
    send_ideal(20);
    check("post_burst_bits", bit_cnt, 29);
    check("post_burst_errs", err_cnt, 8);
    check("post_burst8_errs", err_cnt8, 8);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("lol_held", lol, 1);
`endif
    pulse_clear();
    check("clr2_bits", bit_cnt, 0);
    check("clr2_errs", err_cnt, 0);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("lol_cleared", lol, 0);
`endif

    // Phase change while locked
    i_phase = 2'd2;
    tick(1);
    check("phase_unlock", locked, 0);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("phase_lol", lol, 1);
`endif
    send_ideal(8);
    check("phase_pending", locked, 0);
    send_ideal(1);
    check("phase_relock", locked, 1);
    send_ideal(50);
    check("phase_bits", bit_cnt, 50);
    check("phase_errs", err_cnt, 0);

    // Asynchronous reset mid-CHECK
    #3;
    i_reset = 1'b0;
    #1;
    check("areset_locked", locked, 0);
    check("areset_bits", bit_cnt, 0);
    check("areset_errs", err_cnt, 0);
    check("areset_rx", rx_bit, 0);
`ifdef BER_CHECKER_STICKY_LOL_EN
    check("areset_lol", lol, 0);
`endif
    @(posedge clock);
    #1;
    i_reset = 1'b1;
    tick(1);
    send_ideal(8);
    check("rst_pending", locked, 0);
    send_ideal(1);
    check("rst_relock", locked, 1);
    send_ideal(10);
    check("rst_bits", bit_cnt, 10);

    // Disable: back to IDLE, counters hold
    i_enable = 1'b0;
    tick(1);
    check("dis_unlocked", locked, 0);
    send_ideal(5);
    check("dis_bits", bit_cnt, 10);
    check("dis_errs", err_cnt, 0);
    check("dis_still_idle", locked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
